// File: rtl/sram_icb_arb_if.sv
// ICB bus bundle: one command channel plus one response channel.
// Used for both masters and the shared SRAM slave port.
interface sram_icb_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic [ADDR_W-1:0] icb_cmd_addr;
  logic              icb_cmd_read;
  logic [DATA_W-1:0] icb_cmd_wdata;
  logic [DATA_W/8-1:0] icb_cmd_wmask;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready;
  logic              icb_rsp_err;
  logic [DATA_W-1:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
    output icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err,
    input  icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
    input  icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err,
    output icb_rsp_rdata
  );
endinterface

// File: rtl/sram_icb_arb.sv
// Two-master round-robin ICB arbiter in front of the SRAM slave.
// One transaction in flight; write responses are generated locally.
module sram_icb_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  sram_icb_arb_if.slave  m0,
  sram_icb_arb_if.slave  m1,
  sram_icb_arb_if.master s
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_RSP
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   last;
  logic   gnt;
  logic   hs;

  always_comb begin
    gnt = (m0.icb_cmd_valid & m1.icb_cmd_valid) ? ~last
                                                : m1.icb_cmd_valid;
    state_nxt          = state;
    hs                 = 1'b0;
    s.icb_cmd_valid    = 1'b0;
    s.icb_cmd_addr     = gnt ? m1.icb_cmd_addr  : m0.icb_cmd_addr;
    s.icb_cmd_read     = gnt ? m1.icb_cmd_read  : m0.icb_cmd_read;
    s.icb_cmd_wdata    = gnt ? m1.icb_cmd_wdata : m0.icb_cmd_wdata;
    s.icb_cmd_wmask    = gnt ? m1.icb_cmd_wmask : m0.icb_cmd_wmask;
    s.icb_rsp_ready    = 1'b0;
    m0.icb_cmd_ready   = 1'b0;
    m1.icb_cmd_ready   = 1'b0;
    m0.icb_rsp_valid   = 1'b0;
    m0.icb_rsp_err     = 1'b0;
    m0.icb_rsp_rdata   = '0;
    m1.icb_rsp_valid   = 1'b0;
    m1.icb_rsp_err     = 1'b0;
    m1.icb_rsp_rdata   = '0;
    unique case (state)
      IDLE: begin
        s.icb_cmd_valid  = m0.icb_cmd_valid | m1.icb_cmd_valid;
        m0.icb_cmd_ready = ~gnt & s.icb_cmd_ready;
        m1.icb_cmd_ready =  gnt & s.icb_cmd_ready;
        hs = s.icb_cmd_valid & s.icb_cmd_ready;
        if (hs) begin
          state_nxt = s.icb_cmd_read ? RD_WAIT : WR_RSP;
        end
      end
      RD_WAIT: begin
        if (owner) begin
          s.icb_rsp_ready  = m1.icb_rsp_ready;
          m1.icb_rsp_valid = s.icb_rsp_valid;
          m1.icb_rsp_err   = s.icb_rsp_err;
          m1.icb_rsp_rdata = s.icb_rsp_rdata;
        end else begin
          s.icb_rsp_ready  = m0.icb_rsp_ready;
          m0.icb_rsp_valid = s.icb_rsp_valid;
          m0.icb_rsp_err   = s.icb_rsp_err;
          m0.icb_rsp_rdata = s.icb_rsp_rdata;
        end
        if (s.icb_rsp_valid & s.icb_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      WR_RSP: begin
        if (owner) begin
          m1.icb_rsp_valid = 1'b1;
          if (m1.icb_rsp_ready) state_nxt = IDLE;
        end else begin
          m0.icb_rsp_valid = 1'b1;
          if (m0.icb_rsp_ready) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last starts at 1 so m0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (hs) begin
        owner <= gnt;
        last  <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_sram_icb_arb.sv
// Bench for sram_icb_arb: SRAM slave model plus per-master scoreboards.
// Expected responses are queued at command handshake, popped at response.
module tb_sram_icb_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_icb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  sram_icb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
  sram_icb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

  sram_icb_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0(m0_bus), .m1(m1_bus), .s(s_bus)
  );

  logic          mv [2];
  logic [AW-1:0] ma [2];
  logic          mrd [2];
  logic [DW-1:0] mwd [2];
  logic [MW-1:0] mwm [2];
  logic          rr [2];
  logic          crdy [2];
  logic          rv [2];
  logic          rerr [2];
  logic [DW-1:0] rdat [2];

  assign m0_bus.icb_cmd_valid = mv[0];
  assign m0_bus.icb_cmd_addr  = ma[0];
  assign m0_bus.icb_cmd_read  = mrd[0];
  assign m0_bus.icb_cmd_wdata = mwd[0];
  assign m0_bus.icb_cmd_wmask = mwm[0];
  assign m0_bus.icb_rsp_ready = rr[0];
  assign m1_bus.icb_cmd_valid = mv[1];
  assign m1_bus.icb_cmd_addr  = ma[1];
  assign m1_bus.icb_cmd_read  = mrd[1];
  assign m1_bus.icb_cmd_wdata = mwd[1];
  assign m1_bus.icb_cmd_wmask = mwm[1];
  assign m1_bus.icb_rsp_ready = rr[1];
  assign crdy[0] = m0_bus.icb_cmd_ready;
  assign crdy[1] = m1_bus.icb_cmd_ready;
  assign rv[0]   = m0_bus.icb_rsp_valid;
  assign rv[1]   = m1_bus.icb_rsp_valid;
  assign rerr[0] = m0_bus.icb_rsp_err;
  assign rerr[1] = m1_bus.icb_rsp_err;
  assign rdat[0] = m0_bus.icb_rsp_rdata;
  assign rdat[1] = m1_bus.icb_rsp_rdata;

  // SRAM slave model: 64 words, err on addresses >= 256
  logic [DW-1:0] sram [64];
  logic          s_rdy;
  logic          s_rv;
  logic          s_err;
  logic [DW-1:0] s_rd;

  assign s_bus.icb_cmd_ready = s_rdy;
  assign s_bus.icb_rsp_valid = s_rv;
  assign s_bus.icb_rsp_err   = s_err;
  assign s_bus.icb_rsp_rdata = s_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rv <= 1'b0;
    end else if (s_bus.icb_cmd_valid && s_rdy) begin
      if (s_bus.icb_cmd_read) begin
        s_rv <= 1'b1;
        if (s_bus.icb_cmd_addr < 256) begin
          s_rd  <= sram[s_bus.icb_cmd_addr[7:2]];
          s_err <= 1'b0;
        end else begin
          s_rd  <= '0;
          s_err <= 1'b1;
        end
      end else if (s_bus.icb_cmd_addr < 256) begin
        for (int b = 0; b < MW; b++)
          if (s_bus.icb_cmd_wmask[b])
            sram[s_bus.icb_cmd_addr[7:2]][b*8 +: 8] <=
              s_bus.icb_cmd_wdata[b*8 +: 8];
      end
    end else if (s_rv && s_bus.icb_rsp_ready) begin
      s_rv <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state, owned by the monitor
  logic [DW-1:0] ref_mem [64];
  logic [32:0]   q0 [$];
  logic [32:0]   q1 [$];
  logic [32:0]   e_push;
  logic [32:0]   e_pop;
  logic          pend [2];
  logic          seen [2];
  logic [DW-1:0] held [2];
  int            hs_cyc [2];
  int            rsp_cyc [2];
  logic [DW-1:0] last_rd [2];
  logic          last_err [2];
  int            gnt_m [$];
  int            gnt_c [$];
  logic          popped;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        pend[m] = 1'b0;
        seen[m] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      check("excl_ready", {63'd0, crdy[0] & crdy[1]}, 64'd0);
      for (int m = 0; m < 2; m++) begin
        check("spur_rsp", {63'd0, rv[m] & ~pend[m]}, 64'd0);
        if (rv[m]) begin
          if (!seen[m]) begin
            check("rsp_lat", 64'(cyc - hs_cyc[m]), 64'd1);
            seen[m] = 1'b1;
            held[m] = rdat[m];
          end else begin
            check("rsp_hold", {32'd0, rdat[m]}, {32'd0, held[m]});
          end
          if (rr[m]) begin
            popped = 1'b0;
            if (m == 0 && q0.size() > 0) begin
              e_pop = q0.pop_front();
              popped = 1'b1;
            end
            if (m == 1 && q1.size() > 0) begin
              e_pop = q1.pop_front();
              popped = 1'b1;
            end
            check("sb_pop", {63'd0, popped}, 64'd1);
            if (popped) begin
              check("rsp_err", {63'd0, rerr[m]}, {63'd0, e_pop[32]});
              check("rsp_data", {32'd0, rdat[m]}, {32'd0, e_pop[31:0]});
            end
            last_rd[m]  = rdat[m];
            last_err[m] = rerr[m];
            pend[m]     = 1'b0;
            seen[m]     = 1'b0;
            rsp_cyc[m]  = cyc;
          end
        end
        if (mv[m] && crdy[m]) begin
          if (!mrd[m]) begin
            e_push = {1'b0, 32'd0};
            if (ma[m] < 256)
              for (int b = 0; b < MW; b++)
                if (mwm[m][b])
                  ref_mem[ma[m][7:2]][b*8 +: 8] = mwd[m][b*8 +: 8];
          end else if (ma[m] < 256) begin
            e_push = {1'b0, ref_mem[ma[m][7:2]]};
          end else begin
            e_push = {1'b1, 32'd0};
          end
          if (m == 0) q0.push_back(e_push);
          else        q1.push_back(e_push);
          pend[m]   = 1'b1;
          hs_cyc[m] = cyc;
          gnt_m.push_back(m);
          gnt_c.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input int m, input logic [AW-1:0] a,
                       input logic rd, input logic [DW-1:0] wd,
                       input logic [MW-1:0] wm);
    int n = 0;
    mv[m] = 1'b1;
    ma[m] = a;
    mrd[m] = rd;
    mwd[m] = wd;
    mwm[m] = wm;
    @(negedge clk);
    while (!crdy[m] && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("issue_done", {63'd0, crdy[m]}, 64'd1);
    if (crdy[m]) begin
      @(posedge clk);
      #1;
    end
    mv[m] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend[0] || pend[1] || mv[0] || mv[1]) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("idle_to", {63'd0, n >= 100}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; ma[m] = '0; mrd[m] = 1'b0;
      mwd[m] = '0; mwm[m] = '0; rr[m] = 1'b1;
    end
    s_rdy = 1'b1;
    #12;
    check("rst_state", 64'(dut.state), 64'd0);
    check("rst_owner", {63'd0, dut.owner}, 64'd0);
    check("rst_last", {63'd0, dut.last}, 64'd1);
    check("rst_rv0", {63'd0, rv[0]}, 64'd0);
    check("rst_rv1", {63'd0, rv[1]}, 64'd0);
    check("rst_scv", {63'd0, s_bus.icb_cmd_valid}, 64'd0);
    reset_dut();

    // single master write then read
    issue(0, 32'h10, 1'b0, 32'hDEADBEEF, 4'hF);
    issue(0, 32'h10, 1'b1, '0, '0);
    wait_idle();
    check("t1_rdata", {32'd0, last_rd[0]}, {32'd0, 32'hDEADBEEF});

    // partial write by m1
    issue(1, 32'h20, 1'b0, 32'hAABBCCDD, 4'hF);
    issue(1, 32'h20, 1'b0, 32'h11223344, 4'b0101);
    issue(1, 32'h20, 1'b1, '0, '0);
    wait_idle();
    check("pw_rdata", {32'd0, last_rd[1]}, {32'd0, 32'hAA22CC44});

    // slave cmd_ready low, then out-of-range read
    s_rdy = 1'b0;
    fork
      issue(0, 32'h400, 1'b1, '0, '0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("srdy_lo", {63'd0, crdy[0]}, 64'd0);
        end
        @(posedge clk);
        #1 s_rdy = 1'b1;
      end
    join
    wait_idle();
    check("err_pass", {63'd0, last_err[0]}, 64'd1);

    // response backpressure
    rr[0] = 1'b0;
    issue(0, 32'h10, 1'b1, '0, '0);
    fork
      issue(1, 32'h20, 1'b1, '0, '0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_m1_blk", {63'd0, crdy[1]}, 64'd0);
        end
        @(posedge clk);
        #1 rr[0] = 1'b1;
      end
    join
    check("bp_gnt_m", 64'(gnt_m[gnt_m.size()-1]), 64'd1);
    check("bp_gnt_c", 64'(gnt_c[gnt_c.size()-1] - rsp_cyc[0]), 64'd1);
    wait_idle();
    check("bp_m1_data", {32'd0, last_rd[1]}, {32'd0, 32'hAA22CC44});

    // contention from reset
    reset_dut();
    base = gnt_m.size();
    fork
      begin
        issue(0, 32'h10, 1'b1, '0, '0);
        issue(0, 32'h10, 1'b1, '0, '0);
      end
      begin
        issue(1, 32'h20, 1'b1, '0, '0);
        issue(1, 32'h20, 1'b1, '0, '0);
      end
    join
    wait_idle();
    check("ct_count", 64'(gnt_m.size() - base), 64'd4);
    if (gnt_m.size() >= base + 4) begin
      for (int i = 0; i < 4; i++)
        check("ct_order", 64'(gnt_m[base+i]), 64'(i % 2));
      for (int i = 0; i < 3; i++)
        check("ct_gap", 64'(gnt_c[base+i+1] - gnt_c[base+i]), 64'd2);
    end

    // reset while in RD_WAIT
    rr[0] = 1'b0;
    issue(0, 32'h14, 1'b1, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_state", 64'(dut.state), 64'd0);
    check("mid_rv0", {63'd0, rv[0]}, 64'd0);
    check("mid_rv1", {63'd0, rv[1]}, 64'd0);
    repeat (2) @(posedge clk);
    rr[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = gnt_m.size();
    fork
      issue(0, 32'h10, 1'b1, '0, '0);
      issue(1, 32'h20, 1'b1, '0, '0);
    join
    wait_idle();
    check("rst_tie_n", 64'(gnt_m.size() - base), 64'd2);
    if (gnt_m.size() > base)
      check("rst_tie", 64'(gnt_m[base]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_icb_arb.md
Name: sram_icb_arb

Overview:
- Two-master to one-slave ICB arbiter that shares the on-chip SRAM slave between two requesters:
  - m0: core data/LSU port
  - m1: debug/DMA port
- Round-robin grant, at most one transaction outstanding.
- Read responses are routed back from the slave. The SRAM slave never responds to writes, so write responses are generated locally.
- Sits between the bus masters and the SRAM slave port.

Parameters:
- ADDR_W, 32, ICB command address width.
- DATA_W, 32, ICB data width. The mask width is DATA_W/8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- m0_icb_cmd_valid  in  1  master0 cmd valid
- m0_icb_cmd_ready  out  1  master0 cmd accepted
- m0_icb_cmd_addr  in  ADDR_W  master0 byte address
- m0_icb_cmd_read  in  1  1=read, 0=write
- m0_icb_cmd_wdata  in  DATA_W  master0 write data
- m0_icb_cmd_wmask  in  DATA_W/8  master0 byte enables
- m0_icb_rsp_valid  out  1  master0 response valid
- m0_icb_rsp_ready  in  1  master0 response accepted
- m0_icb_rsp_err  out  1  master0 response error
- m0_icb_rsp_rdata  out  DATA_W  master0 read data
- m1_icb_*  same set and widths as m0_icb_*, for master1
- s_icb_cmd_valid  out  1  slave cmd valid
- s_icb_cmd_ready  in  1  slave cmd ready
- s_icb_cmd_addr  out  ADDR_W  slave address
- s_icb_cmd_read  out  1  slave read flag
- s_icb_cmd_wdata  out  DATA_W  slave write data
- s_icb_cmd_wmask  out  DATA_W/8  slave byte enables
- s_icb_rsp_valid  in  1  slave response valid (reads only; asserts the cycle after the read cmd handshake)
- s_icb_rsp_ready  out  1  slave response accepted
- s_icb_rsp_err  in  1  slave response error
- s_icb_rsp_rdata  in  DATA_W  slave read data

Behaviour:
- Reset is asynchronous on the falling edge of rst_n. Reset values:
  - state = IDLE, owner = 0, last = 1 (so m0 wins the first tie)
  - all m*_icb_rsp_valid = 0, s_icb_cmd_valid = 0
- States:
  - IDLE: no transaction pending.
  - RD_WAIT: waiting for the slave read response.
  - WR_RSP: a local write response is pending.
- IDLE arbitration (combinational):
  - Only m0 valid: grant m0. Only m1 valid: grant m1.
  - Both valid: grant the master that is not `last`.
  - s_icb_cmd_valid = m0_valid | m1_valid.
  - The s_icb_cmd_* payload is muxed from the granted master.
  - The granted master's cmd_ready = s_icb_cmd_ready. The other master's cmd_ready = 0.
- In RD_WAIT and WR_RSP:
  - s_icb_cmd_valid = 0 and both m*_cmd_ready = 0.
  - The slave's read data is held stable because no new command reaches the slave.
- Command handshake (granted valid & s_icb_cmd_ready in IDLE):
  - Register owner <= granted index and last <= granted index.
  - If read: next state RD_WAIT.
  - If write: next state WR_RSP, and the owner's rsp_valid is registered to 1 the following cycle.
- RD_WAIT:
  - Route s_icb_rsp_valid, s_icb_rsp_err and s_icb_rsp_rdata to the owner.
  - s_icb_rsp_ready = owner's rsp_ready.
  - The non-owner's rsp_valid = 0.
  - On s_icb_rsp_valid & s_icb_rsp_ready: go to IDLE.
  - A new command can be granted in the following cycle.
- WR_RSP:
  - Owner's rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
  - rsp_valid holds until the owner's rsp_ready is sampled high; then go to IDLE.
- Outside RD_WAIT, s_icb_rsp_ready = 0.
- Latency:
  - Read: cmd handshake at cycle N, rsp_valid at N+1; with rsp_ready = 1, the next grant is possible at N+2.
  - Write: cmd handshake at N, local rsp_valid at N+1, next grant at N+2.
- Back-to-back requests with both masters continuously valid strictly alternate m0, m1, m0, ...
- A master dropping valid before its cmd_ready is legal. Arbitration is re-evaluated every IDLE cycle; there is no grant lock before the handshake.
- s_icb_cmd_ready = 0 in IDLE: the grant may change next cycle; no state change.
- rsp_ready held low: the arbiter stays in RD_WAIT/WR_RSP indefinitely. Both masters stall; no response is dropped.
- s_icb_rsp_err is passed through unchanged, e.g. an out-of-range read address returns err = 1 to the owner.
- Reset mid-transaction returns the arbiter to IDLE immediately. Any in-flight response is discarded.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to 0x10 with wmask = 4'hF, then reads 0x10 -> write rsp_valid 1 cycle after the cmd handshake with err = 0; read rsp_rdata = 0xDEADBEEF the cycle after the read cmd; m1 sees no rsp.
- Contention: m0 and m1 both hold valid reads from reset -> grants in order m0, m1, m0, m1; each grant 2 cycles apart; each master gets its own data.
- Partial write: m1 writes 0x11223344 to 0x20 with wmask = 4'b0101 over an initial value of 0xAABBCCDD -> a read of 0x20 returns 0xAA22CC44.
- Response backpressure: m0 read with m0 rsp_ready low for 5 cycles while m1 is valid -> m1_cmd_ready stays 0; rdata stays stable; m1 is granted the cycle after the m0 rsp handshake.
- Error pass-through: read of an address beyond the SRAM size -> the owner receives rsp_err = 1.
- Reset: assert rst_n low while in RD_WAIT -> all rsp_valid = 0 and state = IDLE; after release, the first tie is granted to m0.
